// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its bypass muxes.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_REG_DEPTH  = 32;
  localparam int DEF_NUM_READ   = 2;
  localparam int DEF_NUM_WRITE  = 2;
  localparam int DEF_TAG_WIDTH  = 4;
  localparam int DEF_ZERO_REG   = 1;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEF_TAG_WIDTH-1:0]  reg_tag_t;

  localparam int A0_IDX = 10;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-back bypass: the highest-index matching write port supplies the data,
// combinational (0 cycles), accept-always; also flags a same-cycle tag-matching scoreboard clear.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  input  logic [DATA_WIDTH-1:0]                 mem_data,
  input  logic [TAG_WIDTH-1:0]                  mem_tag,
  input  logic [NUM_WRITE-1:0]                  wr_en,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [NUM_WRITE-1:0][TAG_WIDTH-1:0]   wr_tag,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  clr_hit
);

  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    rd_data = mem_data;
    clr_hit = 1'b0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_en[k] && (wr_addr[k] == rd_addr)) begin
        rd_data = wr_data[k];
        if (wr_tag[k] == mem_tag) clr_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write bypass and tagged busy scoreboard; reads 0-cycle,
// writes/issue/flush land at the next edge; no back-pressure, every port accepts every cycle.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_DEPTH  = DEF_REG_DEPTH,
  parameter int NUM_READ   = DEF_NUM_READ,
  parameter int NUM_WRITE  = DEF_NUM_WRITE,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_READ-1:0]                   rd_busy_o,
  input  logic [NUM_WRITE-1:0]                  wr_en_i,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  wr_data_i,
  input  logic [NUM_WRITE-1:0][TAG_WIDTH-1:0]   wr_tag_i,
  input  logic                                  iss_en_i,
  input  logic [ADDR_WIDTH-1:0]                 iss_addr_i,
  input  logic [TAG_WIDTH-1:0]                  iss_tag_i,
  input  logic                                  flush_i,
  output logic                                  a0_reg_lsb_o
);

  logic [DATA_WIDTH-1:0] mem [REG_DEPTH];
  logic [TAG_WIDTH-1:0]  tag [REG_DEPTH];
  logic [REG_DEPTH-1:0]  busy;

  // Index that holds real state: in range and not the hardwired zero register.
  function automatic logic legal_idx(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < REG_DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] byp_data;
    logic                  clr_hit;
    logic                  rd_valid;

    assign a        = rd_addr_i[r];
    assign rd_valid = legal_idx(a);

    regfile_bypass_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WRITE  (NUM_WRITE),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_byp (
      .rd_addr  (a),
      .mem_data (mem[a]),
      .mem_tag  (tag[a]),
      .wr_en    (wr_en_i),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .wr_tag   (wr_tag_i),
      .rd_data  (byp_data),
      .clr_hit  (clr_hit)
    );

    // Same-cycle issue is deliberately invisible here: an instruction never sees its own dest.
    assign rd_data_o[r] = rd_valid ? byp_data : '0;
    assign rd_busy_o[r] = rd_valid && busy[a] && !clr_hit;
  end

  if (REG_DEPTH > A0_IDX) begin : g_a0
    localparam logic [ADDR_WIDTH-1:0] A0_SEL = ADDR_WIDTH'(A0_IDX);
    assign a0_reg_lsb_o = mem[A0_SEL][0];
  end else begin : g_no_a0
    assign a0_reg_lsb_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy <= '0;
      for (int i = 0; i < REG_DEPTH; i++) begin
        mem[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      // Clears compare against the pre-edge tag; a stale (older-tag) write-back leaves busy set.
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wr_en_i[k] && legal_idx(wr_addr_i[k])) begin
          mem[wr_addr_i[k]] <= wr_data_i[k];
          if (wr_tag_i[k] == tag[wr_addr_i[k]]) busy[wr_addr_i[k]] <= 1'b0;
        end
      end
      if (flush_i) begin
        busy <= '0;
      end else if (iss_en_i && legal_idx(iss_addr_i)) begin
        busy[iss_addr_i] <= 1'b1;
        tag[iss_addr_i]  <= iss_tag_i;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed scenarios plus randomized traffic against an array-based reference model.
module tb_register_file_mp;
  import regfile_pkg::*;

  logic                  clk_i;
  logic                  rst_ni;
  logic [1:0][4:0]       rd_addr;
  logic [1:0][63:0]      rd_data;
  logic [1:0]            rd_busy;
  logic [1:0]            wr_en;
  logic [1:0][4:0]       wr_addr;
  logic [1:0][63:0]      wr_data;
  logic [1:0][3:0]       wr_tag;
  logic                  iss_en;
  logic [4:0]            iss_addr;
  logic [3:0]            iss_tag;
  logic                  flush;
  logic                  a0_lsb;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [63:0] m_mem  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  register_file_mp dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_tag_i     (wr_tag),
    .iss_en_i     (iss_en),
    .iss_addr_i   (iss_addr),
    .iss_tag_i    (iss_tag),
    .flush_i      (flush),
    .a0_reg_lsb_o (a0_lsb)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Apply the architectural rules for one clock edge to the reference arrays.
  task automatic model_clock();
    bit clr [32];
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) clr[i] = 0;
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k] != 0 && wr_tag[k] == m_tag[wr_addr[k]]) clr[wr_addr[k]] = 1;
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k] != 0) m_mem[wr_addr[k]] = wr_data[k];
      for (int i = 0; i < 32; i++) if (clr[i]) m_busy[i] = 0;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else if (iss_en && iss_addr != 0) begin
        m_busy[iss_addr] = 1;
        m_tag[iss_addr]  = iss_tag;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_tag = '0;
    iss_en = 0; iss_addr = '0; iss_tag = '0; flush = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle_inputs();
    rd_addr = '0;
    tick();
    tick();
    rst_ni = 1;
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      rd_addr[1] = 5'(31 - a);
      #1;
      for (int r = 0; r < 2; r++) begin
        n_checks++;
        if (rd_data[r] !== 64'h0 || rd_busy[r] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_read port%0d idx%0d: data=%h busy=%b, required data=0 busy=0",
                   r, rd_addr[r], rd_data[r], rd_busy[r]);
        end
      end
    end
    n_checks++;
    if (a0_lsb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a0: got %b, required 0", a0_lsb);
    end
  endtask

  task automatic test_a0();
    wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 64'h1; wr_tag[0] = 4'hF;
    #1;
    n_checks++;
    if (a0_lsb !== 1'b0) begin
      n_fail++;
      $display("FAIL a0_no_bypass: got %b before edge, required 0", a0_lsb);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (a0_lsb !== 1'b1) begin
      n_fail++;
      $display("FAIL a0_after_write: got %b, required 1", a0_lsb);
    end
  endtask

  task automatic test_same_addr();
    wr_en = 2'b11;
    wr_addr[0] = 5'd5; wr_data[0] = 64'hAAAA; wr_tag[0] = 4'h9;
    wr_addr[1] = 5'd5; wr_data[1] = 64'hBBBB; wr_tag[1] = 4'h9;
    rd_addr[0] = 5'd5;
    #1;
    n_checks++;
    if (rd_data[0] !== 64'hBBBB) begin
      n_fail++;
      $display("FAIL same_addr_bypass: got %h, required BBBB", rd_data[0]);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_data[0] !== 64'hBBBB) begin
      n_fail++;
      $display("FAIL same_addr_stored: got %h, required BBBB", rd_data[0]);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_addr = 5'd7; iss_tag = 4'd3;
    rd_addr[0] = 5'd7;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_invisible: busy=%b same cycle as issue, required 0", rd_busy[0]);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_busy: got %b, required 1", rd_busy[0]);
    end
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 64'h77; wr_tag[0] = 4'd2;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 64'h77) begin
      n_fail++;
      $display("FAIL stale_wb_bypass: data=%h busy=%b, required 77/1", rd_data[0], rd_busy[0]);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 64'h77) begin
      n_fail++;
      $display("FAIL stale_wb_stored: data=%h busy=%b, required 77/1", rd_data[0], rd_busy[0]);
    end
    wr_en = 2'b10; wr_addr[1] = 5'd7; wr_data[1] = 64'h78; wr_tag[1] = 4'd3;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 64'h78) begin
      n_fail++;
      $display("FAIL match_wb_bypass: data=%h busy=%b, required 78/0", rd_data[0], rd_busy[0]);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 64'h78) begin
      n_fail++;
      $display("FAIL match_wb_stored: data=%h busy=%b, required 78/0", rd_data[0], rd_busy[0]);
    end
  endtask

  task automatic test_issue_clear_race();
    iss_en = 1; iss_addr = 5'd9; iss_tag = 4'd1;
    tick();
    iss_en = 1; iss_addr = 5'd9; iss_tag = 4'd4;
    wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 64'h99; wr_tag[1] = 4'd1;
    tick();
    idle_inputs();
    rd_addr[1] = 5'd9;
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1 || rd_data[1] !== 64'h99) begin
      n_fail++;
      $display("FAIL race_issue_wins: data=%h busy=%b, required 99/1", rd_data[1], rd_busy[1]);
    end
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 64'h5; wr_tag[0] = 4'd1;
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL race_old_tag: busy=%b with tag1 write-back, required 1", rd_busy[1]);
    end
    wr_tag[0] = 4'd4;
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL race_new_tag: busy=%b with tag4 write-back, required 0", rd_busy[1]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    wr_en = 2'b11;
    wr_addr[0] = 5'd0; wr_data[0] = 64'hFFFF; wr_tag[0] = 4'd0;
    wr_addr[1] = 5'd0; wr_data[1] = 64'hFFFF; wr_tag[1] = 4'd0;
    iss_en = 1; iss_addr = 5'd0; iss_tag = 4'd5;
    rd_addr = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int r = 0; r < 2; r++) begin
        n_checks++;
        if (rd_data[r] !== 64'h0 || rd_busy[r] !== 1'b0) begin
          n_fail++;
          $display("FAIL zero_reg cyc%0d port%0d: data=%h busy=%b, required 0/0",
                   c, r, rd_data[r], rd_busy[r]);
        end
      end
      tick();
      if (c == 1) idle_inputs();
    end
  endtask

  task automatic test_flush();
    iss_en = 1; iss_addr = 5'd3; iss_tag = 4'd1;
    tick();
    iss_addr = 5'd4; iss_tag = 4'd2;
    tick();
    idle_inputs();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    #1;
    n_checks++;
    if (rd_busy !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_pre: busy=%b, required 11", rd_busy);
    end
    flush = 1; iss_en = 1; iss_addr = 5'd6; iss_tag = 4'd7;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_x3x4: busy=%b, required 00", rd_busy);
    end
    rd_addr[0] = 5'd6;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drops_issue: x6 busy=%b, required 0", rd_busy[0]);
    end
  endtask

  task automatic test_reset_midstream();
    wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 64'h3; wr_tag[0] = 4'd0;
    iss_en = 1; iss_addr = 5'd12; iss_tag = 4'd2;
    tick();
    rst_ni = 0;
    wr_en = 2'b11;
    wr_addr[0] = 5'd12; wr_data[0] = 64'h1234; wr_tag[0] = 4'd8;
    wr_addr[1] = 5'd13; wr_data[1] = 64'h5678; wr_tag[1] = 4'd8;
    iss_en = 1; iss_addr = 5'd14; iss_tag = 4'd6;
    tick();
    rst_ni = 1;
    idle_inputs();
    for (int p = 0; p < 2; p++) begin
      rd_addr[0] = (p == 0) ? 5'd12 : 5'd10;
      rd_addr[1] = (p == 0) ? 5'd13 : 5'd14;
      #1;
      for (int r = 0; r < 2; r++) begin
        n_checks++;
        if (rd_data[r] !== 64'h0 || rd_busy[r] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid idx%0d: data=%h busy=%b, required 0/0",
                   rd_addr[r], rd_data[r], rd_busy[r]);
        end
      end
    end
    n_checks++;
    if (a0_lsb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_a0: got %b, required 0", a0_lsb);
    end
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [63:0] exp_d;
    logic        exp_b;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_ni = ($urandom_range(0, 59) != 0);
      for (int k = 0; k < 2; k++) begin
        wr_en[k]   = ($urandom_range(0, 2) != 0);
        wr_addr[k] = 5'($urandom_range(0, 15));
        wr_data[k] = {$urandom, $urandom};
        wr_tag[k]  = 4'($urandom_range(0, 3));
      end
      for (int r = 0; r < 2; r++) rd_addr[r] = 5'($urandom_range(0, 15));
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = 5'($urandom_range(0, 15));
      iss_tag  = 4'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 15) == 0);
      #1;
      for (int r = 0; r < 2; r++) begin
        a = rd_addr[r];
        exp_d = (a == 0) ? 64'h0 : m_mem[a];
        exp_b = (a != 0) && m_busy[a];
        for (int k = 0; k < 2; k++) begin
          if (wr_en[k] && wr_addr[k] == a) begin
            if (a != 0) exp_d = wr_data[k];
            if (wr_tag[k] == m_tag[a]) exp_b = 1'b0;
          end
        end
        n_checks++;
        if (rd_data[r] !== exp_d || rd_busy[r] !== exp_b) begin
          n_fail++;
          $display("FAIL random cyc%0d port%0d idx%0d: data=%h busy=%b, required %h/%b",
                   cyc, r, a, rd_data[r], rd_busy[r], exp_d, exp_b);
        end
      end
      n_checks++;
      if (a0_lsb !== m_mem[10][0]) begin
        n_fail++;
        $display("FAIL random_a0 cyc%0d: got %b, required %b", cyc, a0_lsb, m_mem[10][0]);
      end
      tick();
    end
    rst_ni = 1;
    idle_inputs();
  endtask

  initial begin
    rst_ni = 0;
    rd_addr = '0;
    idle_inputs();
    test_reset();
    test_a0();
    test_same_addr();
    test_scoreboard();
    test_issue_clear_race();
    test_zero_reg();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
